// File: rtl/wb_writeback_unit.sv
// Purpose: MEM/WB consumer; selects the result, drives the scalar RF write port and packs vector lane beats into one vector RF write.
// Latency: 1 cycle for scalar writes and for the write that completes a vector; the forwarding tap updates with the scalar write.
// Backpressure: none. Every beat is accepted, and a partial vector waits indefinitely for its remaining lanes.
// Ports: clk/rst_n; wb_* is the MEM/WB bundle in; rf_* is the scalar write port; vrf_* is the vector write port;
//        fwd_* is the last committed scalar result; lane_busy means a vector is partly collected; vec_err is a sticky error.
module wb_writeback_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        wb_mem_data,
  input  logic [DATA_W-1:0]        wb_alu_result,
  input  logic [ADDR_W-1:0]        wb_rd,
  input  logic                     wb_mem_to_reg,
  input  logic                     wb_reg_write,
  input  logic                     wb_vreg_write,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     vrf_we,
  output logic [ADDR_W-1:0]        vrf_waddr,
  output logic [DATA_W*LANES-1:0]  vrf_wdata,
  output logic                     fwd_valid,
  output logic [ADDR_W-1:0]        fwd_rd,
  output logic [DATA_W-1:0]        fwd_data,
  output logic                     lane_busy,
  output logic                     vec_err
);

  // A single-lane configuration still needs a 1-bit counter to stay legal.
  localparam int LC_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                       state, state_nxt;
  logic [LC_W-1:0]              lc, lc_nxt;
  logic [ADDR_W-1:0]            vaddr, vaddr_nxt;
  logic [LANES-1:0][DATA_W-1:0] lanes, lanes_nxt;
  logic                         vec_fire;
  logic                         err_set;
  logic [DATA_W-1:0]            res;
  logic                         sc_wr;

  assign res       = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
  // A beat that also carries a vector write belongs to the vector path.
  // Writes to x0 are suppressed and never reach the forwarding tap.
  assign sc_wr     = wb_reg_write && !wb_vreg_write && (wb_rd != '0);
  assign lane_busy = (state == COLLECT);

  always_comb begin
    state_nxt = state;
    lc_nxt    = lc;
    vaddr_nxt = vaddr;
    lanes_nxt = lanes;
    vec_fire  = 1'b0;
    err_set   = wb_reg_write && wb_vreg_write;
    case (state)
      IDLE: begin
        if (wb_vreg_write) begin
          lanes_nxt[0] = res;
          vaddr_nxt    = wb_rd;
          if (LANES == 1) begin
            vec_fire = 1'b1;
          end else begin
            lc_nxt    = LC_W'(1);
            state_nxt = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (wb_vreg_write) begin
          if (wb_rd == vaddr) begin
            lanes_nxt[lc] = res;
            if (lc == LC_W'(LANES - 1)) begin
              vec_fire  = 1'b1;
              lc_nxt    = '0;
              state_nxt = IDLE;
            end else begin
              lc_nxt = lc + LC_W'(1);
            end
          end else begin
            // A new destination abandons the partial vector and becomes lane 0 of the new one.
            err_set      = 1'b1;
            lanes_nxt[0] = res;
            vaddr_nxt    = wb_rd;
            lc_nxt       = LC_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lc        <= '0;
      vaddr     <= '0;
      lanes     <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      vrf_we    <= 1'b0;
      vrf_waddr <= '0;
      vrf_wdata <= '0;
      fwd_valid <= 1'b0;
      fwd_rd    <= '0;
      fwd_data  <= '0;
      vec_err   <= 1'b0;
    end else begin
      state  <= state_nxt;
      lc     <= lc_nxt;
      vaddr  <= vaddr_nxt;
      lanes  <= lanes_nxt;
      rf_we  <= sc_wr;
      vrf_we <= vec_fire;
      if (sc_wr) begin
        rf_waddr  <= wb_rd;
        rf_wdata  <= res;
        fwd_valid <= 1'b1;
        fwd_rd    <= wb_rd;
        fwd_data  <= res;
      end
      // The completed vector includes the lane that arrives on this beat.
      if (vec_fire) begin
        vrf_waddr <= vaddr_nxt;
        vrf_wdata <= lanes_nxt;
      end
      if (err_set) begin
        vec_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Purpose: directed self-checking bench for wb_writeback_unit.
// Latency: outputs are sampled 1 time unit after the edge that consumes each beat.
// Backpressure: none; one beat is applied per cycle.
module tb_wb_writeback_unit;

  logic         clk;
  logic         rst_n;
  logic [31:0]  wb_mem_data;
  logic [31:0]  wb_alu_result;
  logic [4:0]   wb_rd;
  logic         wb_mem_to_reg;
  logic         wb_reg_write;
  logic         wb_vreg_write;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic         vrf_we;
  logic [4:0]   vrf_waddr;
  logic [127:0] vrf_wdata;
  logic         fwd_valid;
  logic [4:0]   fwd_rd;
  logic [31:0]  fwd_data;
  logic         lane_busy;
  logic         vec_err;

  int checks = 0;
  int errors = 0;

  wb_writeback_unit #(.DATA_W(32), .ADDR_W(5), .LANES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_mem_data   (wb_mem_data),
    .wb_alu_result (wb_alu_result),
    .wb_rd         (wb_rd),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_vreg_write (wb_vreg_write),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .vrf_we        (vrf_we),
    .vrf_waddr     (vrf_waddr),
    .vrf_wdata     (vrf_wdata),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
    .lane_busy     (lane_busy),
    .vec_err       (vec_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one beat, then return 1 time unit after the edge that consumes it.
  task automatic beat(input logic vreg, input logic sreg, input logic m2r,
                      input logic [4:0] rd, input logic [31:0] mem, input logic [31:0] alu);
    wb_vreg_write = vreg;
    wb_reg_write  = sreg;
    wb_mem_to_reg = m2r;
    wb_rd         = rd;
    wb_mem_data   = mem;
    wb_alu_result = alu;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic vbeat(input logic [4:0] rd, input logic [31:0] alu);
    beat(1'b1, 1'b0, 1'b0, rd, 32'h0, alu);
  endtask

  initial begin
    rst_n         = 1'b0;
    wb_mem_data   = '0;
    wb_alu_result = '0;
    wb_rd         = '0;
    wb_mem_to_reg = 1'b0;
    wb_reg_write  = 1'b0;
    wb_vreg_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", {127'd0, rf_we}, 128'd0);
    chk("rst_vrf_we", {127'd0, vrf_we}, 128'd0);
    chk("rst_vrf_wdata", vrf_wdata, 128'd0);
    chk("rst_fwd_valid", {127'd0, fwd_valid}, 128'd0);
    chk("rst_busy_err", {126'd0, lane_busy, vec_err}, 128'd0);
    rst_n = 1'b1;

    // Reset in the middle of a collection drops the partial vector without an error.
    vbeat(5'd3, 32'hA0A0A0A0);
    vbeat(5'd3, 32'hA1A1A1A1);
    chk("mid_busy", {127'd0, lane_busy}, 128'd1);
    idle();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_busy", {127'd0, lane_busy}, 128'd0);
    chk("mid_rst_err", {127'd0, vec_err}, 128'd0);
    chk("mid_rst_vrf", {122'd0, vrf_we, vrf_waddr}, 128'd0);
    chk("mid_rst_wdata", vrf_wdata, 128'd0);
    rst_n = 1'b1;
    vbeat(5'd3, 32'h00000001);
    vbeat(5'd3, 32'h00000002);
    vbeat(5'd3, 32'h00000003);
    chk("v3_no_early", {127'd0, vrf_we}, 128'd0);
    vbeat(5'd3, 32'h00000004);
    chk("v3_we", {127'd0, vrf_we}, 128'd1);
    chk("v3_addr", {123'd0, vrf_waddr}, 128'd3);
    chk("v3_data", vrf_wdata, 128'h00000004_00000003_00000002_00000001);
    chk("v3_busy", {127'd0, lane_busy}, 128'd0);
    idle();
    chk("v3_pulse", {127'd0, vrf_we}, 128'd0);
    chk("v3_hold", vrf_wdata, 128'h00000004_00000003_00000002_00000001);

    // Scalar writes: memory select, x0 suppression, ALU select.
    beat(1'b0, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 32'h0);
    chk("s7_we", {127'd0, rf_we}, 128'd1);
    chk("s7_addr", {123'd0, rf_waddr}, 128'd7);
    chk("s7_data", {96'd0, rf_wdata}, {96'd0, 32'hDEADBEEF});
    chk("s7_fwd", {90'd0, fwd_valid, fwd_rd, fwd_data}, {90'd0, 1'b1, 5'd7, 32'hDEADBEEF});
    beat(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h5);
    chk("s0_we", {127'd0, rf_we}, 128'd0);
    chk("s0_fwd", {90'd0, fwd_valid, fwd_rd, fwd_data}, {90'd0, 1'b1, 5'd7, 32'hDEADBEEF});
    beat(1'b0, 1'b1, 1'b0, 5'd10, 32'hFFFF0000, 32'h00001234);
    chk("s10_data", {90'd0, rf_we, rf_waddr, rf_wdata}, {90'd0, 1'b1, 5'd10, 32'h00001234});
    idle();
    chk("s_idle_we", {127'd0, rf_we}, 128'd0);
    chk("s_idle_fwd", {96'd0, fwd_data}, {96'd0, 32'h00001234});

    // Vector pack to v2.
    vbeat(5'd2, 32'h11111111);
    vbeat(5'd2, 32'h22222222);
    vbeat(5'd2, 32'h33333333);
    vbeat(5'd2, 32'h44444444);
    chk("v2_we_addr", {122'd0, vrf_we, vrf_waddr}, {122'd0, 1'b1, 5'd2});
    chk("v2_data", vrf_wdata, 128'h44444444_33333333_22222222_11111111);
    chk("v2_no_err", {127'd0, vec_err}, 128'd0);

    // A scalar beat and an idle beat interleaved within a collection.
    vbeat(5'd5, 32'h55000000);
    vbeat(5'd5, 32'h55000001);
    beat(1'b0, 1'b1, 1'b0, 5'd9, 32'h0, 32'h0000000A);
    chk("il_scalar", {90'd0, rf_we, rf_waddr, rf_wdata}, {90'd0, 1'b1, 5'd9, 32'h0000000A});
    chk("il_busy", {126'd0, lane_busy, vrf_we}, {126'd0, 2'b10});
    idle();
    chk("il_idle_busy", {127'd0, lane_busy}, 128'd1);
    vbeat(5'd5, 32'h55000002);
    chk("il_no_early", {127'd0, vrf_we}, 128'd0);
    vbeat(5'd5, 32'h55000003);
    chk("il_we_addr", {122'd0, vrf_we, vrf_waddr}, {122'd0, 1'b1, 5'd5});
    chk("il_data", vrf_wdata, 128'h55000003_55000002_55000001_55000000);

    // Address mismatch: the v4 partial is discarded and v6 restarts at lane 0.
    vbeat(5'd4, 32'hC4000000);
    vbeat(5'd4, 32'hC4000001);
    chk("mm_err_before", {127'd0, vec_err}, 128'd0);
    vbeat(5'd6, 32'hE0000000);
    chk("mm_err", {127'd0, vec_err}, 128'd1);
    chk("mm_no_we", {127'd0, vrf_we}, 128'd0);
    vbeat(5'd6, 32'hE0000001);
    vbeat(5'd6, 32'hE0000002);
    chk("mm_no_early", {127'd0, vrf_we}, 128'd0);
    vbeat(5'd6, 32'hE0000003);
    chk("mm_we_addr", {122'd0, vrf_we, vrf_waddr}, {122'd0, 1'b1, 5'd6});
    chk("mm_data", vrf_wdata, 128'hE0000003_E0000002_E0000001_E0000000);
    idle();
    chk("mm_sticky", {126'd0, vec_err, vrf_we}, {126'd0, 2'b10});

    // Reset clears vec_err; then a combined scalar+vector beat to rd 8 is a conflict.
    rst_n = 1'b0;
    #2;
    chk("cf_rst", {125'd0, vec_err, fwd_valid, lane_busy}, 128'd0);
    rst_n = 1'b1;
    beat(1'b1, 1'b1, 1'b0, 5'd8, 32'h0, 32'h88888888);
    chk("cf_rf_we", {127'd0, rf_we}, 128'd0);
    chk("cf_busy_err", {126'd0, lane_busy, vec_err}, {126'd0, 2'b11});
    chk("cf_fwd", {127'd0, fwd_valid}, 128'd0);
    vbeat(5'd8, 32'h88888889);
    vbeat(5'd8, 32'h8888888A);
    vbeat(5'd8, 32'h8888888B);
    chk("cf_we_addr", {122'd0, vrf_we, vrf_waddr}, {122'd0, 1'b1, 5'd8});
    chk("cf_data", vrf_wdata, 128'h8888888B_8888888A_88888889_88888888);

    // Vector destination 0 is legal.
    vbeat(5'd0, 32'h00000010);
    vbeat(5'd0, 32'h00000020);
    vbeat(5'd0, 32'h00000030);
    vbeat(5'd0, 32'h00000040);
    chk("v0_we_addr", {122'd0, vrf_we, vrf_waddr}, {122'd0, 1'b1, 5'd0});
    chk("v0_data", vrf_wdata, 128'h00000040_00000030_00000020_00000010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
